// File: rtl/mersenne_pkg.sv
// Shared vocabulary for the Mersenne datapath: operand width, FSM state
// encodings for the multiplier and the modulo checker, and small bit helpers.
package mersenne_pkg;

  localparam int NUMBER_LENGTH = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } mult_state_t;

  // Checker states share the 2-bit encoding space with the multiplier.
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_multiplier_if.sv
// Start/result handshake between a requester and the bit-serial multiplier.
interface serial_multiplier_if #(
  parameter int N = mersenne_pkg::NUMBER_LENGTH
) ();

  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/serial_full_adder.sv
// One-bit full adder with a registered carry; the sum is combinational so the
// caller can write it back into its accumulator on the same edge.
module serial_full_adder
  import mersenne_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry,
  output logic carry_next
);

  logic carry_reg;

  assign sum        = x ^ y ^ carry_reg;
  assign carry_next = majority(x, y, carry_reg);
  assign carry      = carry_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      carry_reg <= 1'b0;
    end else if (en) begin
      carry_reg <= carry_next;
    end
  end

endmodule

// File: rtl/serial_multiplier.sv
// Bit-serial shift-and-add multiplier: scans multiplier bits and, for each set
// bit, ripples the multiplicand into the accumulator one full-adder step per clock.
module serial_multiplier
  import mersenne_pkg::*;
#(
  parameter int N = NUMBER_LENGTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_multiplier_if.slave  bus
);

  localparam int IW = $clog2(N + 1);
  localparam int AW = $clog2(2 * N);

  mult_state_t      state_reg, state_next;
  logic [N-1:0]     a_reg, b_reg;
  logic [2*N-1:0]   acc_reg, acc_next;
  logic [IW-1:0]    row_reg, col_reg;
  logic [2*N-1:0]   product_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [AW-1:0]    bit_idx;
  logic             fa_x, fa_y, fa_sum, fa_carry, fa_carry_next;
  logic             fa_clr, fa_en;
  logic             row_at_end, col_at_end;

  assign row_at_end = (row_reg == IW'(N));
  assign col_at_end = (col_reg == IW'(N));
  assign bit_idx    = AW'(row_reg) + AW'(col_reg);

  // Past the top of the multiplicand the adder only propagates the carry.
  assign fa_x = (col_reg < IW'(N)) ? a_reg[col_reg] : 1'b0;
  assign fa_y = acc_reg[bit_idx];

  serial_full_adder u_fa (
    .clk        (clk),
    .rst        (rst),
    .clr        (fa_clr),
    .en         (fa_en),
    .x          (fa_x),
    .y          (fa_y),
    .sum        (fa_sum),
    .carry      (fa_carry),
    .carry_next (fa_carry_next)
  );

  // Only the accumulator bit under the current row+col position is rewritten.
  generate
    for (genvar gi = 0; gi < 2 * N; gi++) begin : g_acc
      assign acc_next[gi] = (bit_idx == AW'(gi)) ? fa_sum : acc_reg[gi];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (bus.start) state_next = S_SCAN;
      S_SCAN: begin
        if (row_at_end)            state_next = S_DONE;
        else if (b_reg[row_reg])   state_next = S_ADD;
      end
      S_ADD:  if (col_at_end) state_next = S_SCAN;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy_next = (state_next == S_SCAN) || (state_next == S_ADD);
    done_next = (state_next == S_DONE);
    fa_en     = (state_reg == S_ADD);
    fa_clr    = ((state_reg == S_IDLE) && bus.start) ||
                ((state_reg == S_SCAN) && (state_next == S_ADD));
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      product_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      done_reg <= done_next;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            acc_reg <= '0;
            row_reg <= '0;
            col_reg <= '0;
          end
        end
        S_SCAN: begin
          if (row_at_end) begin
            product_reg <= acc_reg;
          end else if (b_reg[row_reg]) begin
            col_reg <= '0;
          end else begin
            row_reg <= row_reg + 1'b1;
          end
        end
        S_ADD: begin
          acc_reg <= acc_next;
          if (col_at_end) begin
            row_reg <= row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.product = product_reg;

endmodule

// File: tb/tb_serial_multiplier.sv
// Directed bench for serial_multiplier: table of operand/product/latency
// vectors plus hand-written sequences for held start and mid-run reset.
module tb_serial_multiplier;
  import mersenne_pkg::*;

  localparam int N = NUMBER_LENGTH;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] product;
    int             latency;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  serial_multiplier_if #(.N(N)) bus ();

  serial_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // The carry out of the last column of a row must never be set.
  always @(negedge clk) begin
    if (!rst && dut.state_reg == S_ADD && dut.col_reg == 4'(N) && dut.fa_carry_next) begin
      fails++;
      $display("FAIL carry_out: got 1, expected 0 (row %0d)", dut.row_reg);
    end
  end

  // Issue one start, measure latency to done, check busy, product and done width.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_b,
                        input logic [2*N-1:0] exp_p, input int exp_lat);
    int   cnt;
    bit   seen;
    logic busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_ok   = bus.busy;
    cnt       = 0;
    seen      = 0;
    while (!seen && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.done) seen = 1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    $display("[TB] a=%0d b=%0d product=%0d latency=%0d", ta, tb_b, bus.product, cnt);
    check("latency", 64'(cnt), 64'(exp_lat));
    check("product", 64'(bus.product), 64'(exp_p));
    check("busy_during_op", 64'(busy_ok), 64'd1);
    check("busy_at_done", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check("done_width", 64'(bus.done), 64'd0);
    check("product_hold", 64'(bus.product), 64'(exp_p));
  endtask

  vec_t vecs[5];

  initial begin
    int   cnt;
    bit   seen;

    vecs[0] = '{a: 9'd14,  b: 9'd503, product: 18'd7042,   latency: 90};
    vecs[1] = '{a: 9'd511, b: 9'd511, product: 18'd261121, latency: 100};
    vecs[2] = '{a: 9'd37,  b: 9'd0,   product: 18'd0,      latency: 10};
    vecs[3] = '{a: 9'd0,   b: 9'd511, product: 18'd0,      latency: 100};
    vecs[4] = '{a: 9'd2,   b: 9'd3,   product: 18'd6,      latency: 30};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].product, vecs[i].latency);
    end

    // start held high: operands changed after accept must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 9'd3;
    bus.b     = 9'd5;
    @(posedge clk);
    #1;
    bus.a = 9'd7;
    bus.b = 9'd7;
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.done) seen = 1;
    end
    $display("[TB] held-start a=3 b=5 product=%0d latency=%0d", bus.product, cnt);
    check("held_latency", 64'(cnt), 64'd30);
    check("held_product", 64'(bus.product), 64'd15);
    @(posedge clk);
    #1;
    check("held_idle_gap_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check("held_second_accept_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.done) seen = 1;
    end
    $display("[TB] held-start second a=7 b=7 product=%0d latency=%0d", bus.product, cnt);
    check("held_second_latency", 64'(cnt), 64'd40);
    check("held_second_product", 64'(bus.product), 64'd49);
    @(posedge clk);

    // reset in the middle of a long operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 9'd14;
    bus.b     = 9'd503;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] mid-run reset busy=%0d done=%0d product=%0d", bus.busy, bus.done, bus.product);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_product", 64'(bus.product), 64'd0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1;
    end
    check("midrst_no_activity", 64'(seen), 64'd0);
    run_op(9'd2, 9'd3, 18'd6, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_multiplier.md
# serial_multiplier

Bit-serial shift-and-add multiplier that produces the 2N-bit operand consumed by the bit-serial modulo/divisibility checker in the Mersenne datapath; it is the forward (multiply/square) half of each Lucas–Lehmer step, where the checker is the reducing half. Operands are captured on a start handshake and multiplied one partial-product bit per clock with a single carry flop. The product is presented with a one-cycle done pulse and held until the next accepted start.

## Interface
- NUMBER_LENGTH, 9, operand width N; product width is 2N.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in S_IDLE.
- a  in  NUMBER_LENGTH  multiplicand, sampled on the accept edge.
- b  in  NUMBER_LENGTH  multiplier, sampled on the accept edge.
- busy  out  1  high in S_SCAN and S_ADD.
- done  out  1  one-cycle pulse, high only in S_DONE.
- product  out  2*NUMBER_LENGTH  a*b, valid from done onward.

## Operation
- Internal registers: a_reg, b_reg (N bits each), acc (2N bits), row (0..N), col (0..N), carry (1 bit).
- S_IDLE: when start=1, load a_reg=a and b_reg=b, clear acc, row, col and carry, then go to S_SCAN. When start=0, stay.
- S_SCAN:
  - row==N: go to S_DONE.
  - b_reg[row]==1: col=0, carry=0, go to S_ADD.
  - otherwise: row=row+1 and stay in S_SCAN.
- S_ADD: one full-adder step per cycle.
  - Inputs are x = (col<N ? a_reg[col] : 0), y = acc[row+col] and carry.
  - acc[row+col] = x^y^carry; carry = majority(x,y,carry).
  - At col==N: row=row+1, go to S_SCAN. Otherwise col=col+1.
- S_DONE: product=acc, done=1, go to S_IDLE unconditionally.
- Width rule: before row r is added, acc < 2^(N+r). The carry out of the col==N step is therefore always 0 and needs no storage. Bench checks this with an assertion.
- Reset values: state=S_IDLE, busy=0, done=0, product=0, and all internal registers 0.
- Boundary behaviour:
  - start while busy, or in the S_DONE cycle: ignored. Operands are not resampled.
  - b=0 or a=0: the multiply still runs its full schedule. a=0 takes ADD passes but leaves acc at 0.
  - rst mid-operation: next edge returns all state to reset values. product is cleared and no done pulse is issued.
  - rst and start asserted together: rst wins.
- product changes only on entry to S_DONE or on rst.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- The accept edge is the edge where start=1 in S_IDLE.
- Latency:
  - p = popcount(b).
  - done is high in the cycle starting (p+1)*(N+1) edges after the accept edge.
  - S_SCAN occupies N+1 cycles; S_ADD occupies p*(N+1) cycles.
- busy rises on the accept edge and falls on the edge that enters S_DONE.
- done is high for exactly 1 cycle.
- Back-to-back operation: the earliest next accept edge is the edge ending the first S_IDLE cycle after S_DONE. Minimum gap between done and the next busy is 1 cycle.

## Structure
- Shared package mersenne_pkg holds:
  - NUMBER_LENGTH default.
  - Multiplier state enum: S_IDLE, S_SCAN, S_ADD, S_DONE.
  - The checker's S_COMP, S_SUB and S_END constants, so both blocks share one state vocabulary.
- Sub-module serial_full_adder: combinational x^y^c plus carry flop with synchronous clear, carrying its own clk/rst. The checker reuses it with a borrow variant in a later cleanup.
- Top FSM, counters and acc live in serial_multiplier.

## Test plan
- Reset, then a=14, b=503 (p=8), start for 1 cycle:
  - done exactly 90 cycles after the accept edge.
  - product=7042 (18'h01B82).
  - busy high for those 90 cycles.
- a=511, b=511: product=261121, latency 100 cycles, no carry-out assertion fires.
- a=37, b=0: product=0, latency 10 cycles.
- a=0, b=511: product=0, latency 100 cycles.
- start held high across a full operation with a=3, b=5:
  - product=15.
  - Mid-run operand changes to a=7, b=7 are ignored.
  - The second accept occurs only after the S_IDLE cycle following done.
- rst pulsed 1 cycle at cycle 40 of a=14, b=503:
  - Next cycle busy=0, done=0, product=0.
  - No done pulse follows.
  - A fresh start with a=2, b=3 yields product=6 after 30 cycles.
